// File: rtl/seq_lock_ctrl.sv
// ---------------------------------------------------------------------------
// seq_lock_ctrl
// Parametrised switch-sequence password lock. The user presses start, then
// raises and lowers single switches to enter digits (digit = switch index),
// and presses end. A correct code unlocks. Wrong codes increment a
// consecutive-failure counter, and reaching MAX_FAIL locks the panel for
// LOCK_CYC cycles. Entering more digits than the code has is a failure.
//
// Ports
//   clk         system clock
//   rst_n       synchronous active-low reset
//   sw          slide switches (already synchronous)
//   btn_start   start button, active-low, idle 1
//   btn_end     end button, active-low, idle 1
//   led         progress bar, led[i]=1 for i<entry count
//   fnd_cnt     active-low 7-seg {g..a}, hex digit of the entry count
//   fnd_status  active-low 7-seg {g..a}: blank / '-' / 'C' / 'E' / 'L'
//   unlock      high in PASS
//   fail        high in FAIL
//   locked      high in LOCKED
//   fail_cnt    consecutive failures so far
// ---------------------------------------------------------------------------
module seq_lock_ctrl #(
    parameter int          SW_W     = 10,
    parameter int          CODE_LEN = 3,
    parameter logic [31:0] CODE     = 32'h520,
    parameter int          MAX_FAIL = 3,
    parameter int          LOCK_CYC = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [SW_W-1:0] sw,
    input  logic            btn_start,
    input  logic            btn_end,
    output logic [7:0]      led,
    output logic [6:0]      fnd_cnt,
    output logic [6:0]      fnd_status,
    output logic            unlock,
    output logic            fail,
    output logic            locked,
    output logic [2:0]      fail_cnt
);

    localparam int TMR_W = $clog2(LOCK_CYC + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_ENTRY, S_CHECK, S_PASS, S_FAIL, S_LOCKED
    } state_t;

    state_t            r_state, w_next;
    logic [3:0]        r_entry_cnt;
    logic              r_mismatch, r_overflow;
    logic [2:0]        r_fail_cnt;
    logic [TMR_W-1:0]  r_timer;
    logic [SW_W-1:0]   r_sw_prev;
    logic              r_bs_prev, r_be_prev;

    logic              w_start_press, w_end_press, w_entry, w_onehot;
    logic [3:0]        w_digit, w_code_digit;
    logic              w_pass, w_lock_now;

    function automatic logic [6:0] seg_hex(input logic [3:0] v);
        case (v)
            4'h0: seg_hex = 7'b1000000;
            4'h1: seg_hex = 7'b1111001;
            4'h2: seg_hex = 7'b0100100;
            4'h3: seg_hex = 7'b0110000;
            4'h4: seg_hex = 7'b0011001;
            4'h5: seg_hex = 7'b0010010;
            4'h6: seg_hex = 7'b0000010;
            4'h7: seg_hex = 7'b1111000;
            4'h8: seg_hex = 7'b0000000;
            4'h9: seg_hex = 7'b0010000;
            4'hA: seg_hex = 7'b0001000;
            4'hB: seg_hex = 7'b0000011;
            4'hC: seg_hex = 7'b1000110;
            4'hD: seg_hex = 7'b0100001;
            4'hE: seg_hex = 7'b0000110;
            default: seg_hex = 7'b0001110;
        endcase
    endfunction

    assign w_start_press = r_bs_prev & ~btn_start;
    assign w_end_press   = r_be_prev & ~btn_end;
    // A new digit only when the switches leave the all-down position.
    assign w_entry       = (r_sw_prev == '0) && (sw != '0);
    assign w_onehot      = ((sw & (sw - 1'b1)) == '0);

    always_comb begin
        w_digit = 4'd0;
        for (int i = 0; i < SW_W; i++)
            if (sw[i]) w_digit = 4'(i);
    end

    always_comb begin
        w_code_digit = 4'd0;
        for (int i = 0; i < CODE_LEN; i++)
            if (r_entry_cnt == 4'(i)) w_code_digit = CODE[4*i +: 4];
    end

    assign w_pass     = (r_entry_cnt == 4'(CODE_LEN)) && !r_mismatch && !r_overflow;
    assign w_lock_now = (({1'b0, r_fail_cnt} + 4'd1) == 4'(MAX_FAIL));

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    // Next-state logic; start beats end when both are pressed together
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (w_start_press) w_next = S_ENTRY;
            S_ENTRY:  if (w_start_press) w_next = S_ENTRY;
                      else if (w_end_press) w_next = S_CHECK;
            S_CHECK:  w_next = w_pass ? S_PASS : (w_lock_now ? S_LOCKED : S_FAIL);
            S_PASS,
            S_FAIL:   if (w_start_press) w_next = S_ENTRY;
            S_LOCKED: if (r_timer == TMR_W'(1)) w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    // Entry counters, failure counter, lockout timer and edge-detect history
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_entry_cnt <= '0;
            r_mismatch  <= 1'b0;
            r_overflow  <= 1'b0;
            r_fail_cnt  <= '0;
            r_timer     <= '0;
            r_sw_prev   <= '0;
            r_bs_prev   <= 1'b1;
            r_be_prev   <= 1'b1;
        end else begin
            r_sw_prev <= sw;
            r_bs_prev <= btn_start;
            r_be_prev <= btn_end;
            case (r_state)
                S_IDLE, S_PASS, S_FAIL, S_ENTRY: begin
                    if (w_start_press) begin
                        r_entry_cnt <= '0;
                        r_mismatch  <= 1'b0;
                        r_overflow  <= 1'b0;
                    end else if (r_state == S_ENTRY && w_entry) begin
                        // Entry coincident with end is still recorded.
                        if (r_entry_cnt < 4'(CODE_LEN)) begin
                            if (!w_onehot || (w_digit != w_code_digit))
                                r_mismatch <= 1'b1;
                            r_entry_cnt <= r_entry_cnt + 4'd1;
                        end else begin
                            r_overflow <= 1'b1;
                        end
                    end
                end
                S_CHECK: begin
                    if (w_pass) begin
                        r_fail_cnt <= '0;
                    end else if (w_lock_now) begin
                        r_fail_cnt <= 3'(MAX_FAIL);
                        r_timer    <= TMR_W'(LOCK_CYC);
                    end else begin
                        r_fail_cnt <= r_fail_cnt + 3'd1;
                    end
                end
                S_LOCKED: begin
                    r_timer <= r_timer - TMR_W'(1);
                    if (r_timer == TMR_W'(1)) r_fail_cnt <= '0;
                end
                default: ;
            endcase
        end
    end

    // Output decode from registered state only
    always_comb begin
        for (int i = 0; i < 8; i++)
            led[i] = (4'(i) < r_entry_cnt);
        fnd_cnt  = seg_hex(r_entry_cnt);
        fail_cnt = r_fail_cnt;
        unlock   = (r_state == S_PASS);
        fail     = (r_state == S_FAIL);
        locked   = (r_state == S_LOCKED);
        case (r_state)
            S_ENTRY,
            S_CHECK:  fnd_status = 7'b0111111;
            S_PASS:   fnd_status = 7'b1000110;
            S_FAIL:   fnd_status = 7'b0000110;
            S_LOCKED: fnd_status = 7'b1000111;
            default:  fnd_status = 7'b1111111;
        endcase
    end

endmodule
